// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, the bubble
// encoding, opcode constants and the fetch-stage state enum.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;

  // Opcode 4'b1000 decodes to all-zero controls, so a bubble is never HALT.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h8000;

  localparam logic [OP_W-1:0] OP_HALT = 4'b0000;
  localparam logic [OP_W-1:0] OP_ANDI = 4'b0001;
  localparam logic [OP_W-1:0] OP_ORI  = 4'b0010;
  localparam logic [OP_W-1:0] OP_BGT  = 4'b0100;
  localparam logic [OP_W-1:0] OP_BLT  = 4'b0101;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b0110;
  localparam logic [OP_W-1:0] OP_JMP  = 4'b0111;
  localparam logic [OP_W-1:0] OP_LBU  = 4'b1010;
  localparam logic [OP_W-1:0] OP_SB   = 4'b1011;
  localparam logic [OP_W-1:0] OP_LW   = 4'b1100;
  localparam logic [OP_W-1:0] OP_SW   = 4'b1101;
  localparam logic [OP_W-1:0] OP_A    = 4'b1111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory
// (slave). The memory is read combinationally: imem_rdata reflects
// imem_addr in the same cycle; there is no valid/ready handshake.
interface fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: reset, bubble, load, otherwise hold.
// A bubble replaces the instruction with NOP_INSTR and clears valid while
// the pc fields keep their previous values.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_pc_next,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_next,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_next;
  logic               r_valid;

  // Register update: reset, bubble insertion, normal load or hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr   <= NOP_INSTR[INSTR_W-1:0];
      r_pc      <= '0;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else if (i_bubble) begin
      r_instr   <= NOP_INSTR[INSTR_W-1:0];
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_pc_next <= i_pc_next;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pc_next = r_pc_next;
  assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and next-PC selection, drives the
// instruction memory, and feeds the IF/ID register. Halt is terminal
// until reset. if_id_valid marks a real instruction (0 = bubble).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W      = cpu_pkg::PC_W,
  parameter int              INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] PC_INC    = 16'd2,
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               pc_op,
  input  logic               b_jmp,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               if_flush,
  input  logic               halt,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_next,
  output logic               if_id_valid,
  output logic [3:0]         opcode,
  output logic               halted,
  output fetch_state_t       dbg_state
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_halted;

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic            w_load;
  logic            w_bubble;

  // Wraps modulo 2^PC_W by construction.
  assign w_pc_inc = r_pc + PC_INC;
  assign w_target = b_jmp ? branch_target : jump_target;

  // IF/ID control in priority order: halt, redirect, flush, stall, fetch.
  // A redirect ignores stall; in HALTED the register simply holds.
  always_comb begin
    w_load   = 1'b0;
    w_bubble = 1'b0;
    if (r_state == RUN) begin
      if (halt) begin
        w_bubble = 1'b1;
      end else if (pc_op) begin
        if (if_flush) w_bubble = 1'b1;
        else          w_load   = 1'b1;
      end else if (if_flush) begin
        w_bubble = 1'b1;
      end else if (!stall) begin
        w_load = 1'b1;
      end
    end
  end

  // Fetch FSM: state, PC and the registered halted flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else if (pc_op) begin
            r_pc <= w_target;
          end else if (!stall) begin
            // Covers both plain fetch and flush-without-stall.
            r_pc <= w_pc_inc;
          end
        end
        HALTED: begin
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_bubble  (w_bubble),
    .i_instr   (imem.imem_rdata),
    .i_pc      (r_pc),
    .i_pc_next (w_pc_inc),
    .o_instr   (if_id_instr),
    .o_pc      (if_id_pc),
    .o_pc_next (if_id_pc_next),
    .o_valid   (if_id_valid)
  );

  assign imem.imem_addr = r_pc;
  assign opcode         = if_id_instr[INSTR_W-1 -: 4];
  assign halted         = r_halted;
  assign dbg_state      = r_state;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU.
- Executes the redirect, flush and halt commands issued by the control unit (pc_op, b_jmp, if_flush, halt).
- Returns the fetched instruction's opcode to the control unit.
- Owns the PC, the sequential/branch/jump next-PC selection, bubble insertion and the terminal HALTED state.

Parameters:
- PC_W, 16, PC and address width.
- INSTR_W, 16, instruction width; opcode is the top 4 bits.
- PC_INC, 2, byte increment per sequential fetch.
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h8000, bubble encoding; opcode 4'b1000 decodes to all-zero controls, so a bubble is never HALT (4'b0000).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- stall  in  1  hazard hold: freeze PC and IF/ID
- pc_op  in  1  redirect PC this cycle
- b_jmp  in  1  redirect source: 1 = branch_target, 0 = jump_target
- branch_target  in  PC_W  branch destination computed in ID
- jump_target  in  PC_W  jump destination computed in ID
- if_flush  in  1  load bubble into IF/ID
- halt  in  1  stop fetching permanently
- imem_addr  out  PC_W  instruction memory address (= PC register)
- imem_rdata  in  INSTR_W  combinational instruction memory read data
- if_id_instr  out  INSTR_W  registered instruction
- if_id_pc  out  PC_W  PC of if_id_instr
- if_id_pc_next  out  PC_W  if_id_pc + PC_INC
- if_id_valid  out  1  0 for bubbles
- opcode  out  4  if_id_instr[INSTR_W-1 -: 4], fed to the control unit
- halted  out  1  1 while in HALTED state

Behaviour:
- Reset (reset==0 at a rising edge) overrides everything. State RUN, PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_next=0, if_id_valid=0, halted=0. Reset mid-redirect or mid-halt discards the pending command.
- imem_addr is driven directly from the PC register. The instruction is captured in the same cycle it is addressed, so fetch-to-IF/ID latency is 1 cycle.
- States: RUN, HALTED.
- RUN, per-edge priority:
  1. halt=1: go to HALTED. PC holds. IF/ID gets a bubble (NOP_INSTR, valid=0, pc fields hold).
  2. pc_op=1: PC <= b_jmp ? branch_target : jump_target. If if_flush=1, IF/ID gets a bubble; otherwise IF/ID loads imem_rdata/PC normally. stall is ignored.
  3. if_flush=1 (no pc_op): IF/ID gets a bubble. PC <= PC+PC_INC unless stall=1, in which case PC holds.
  4. stall=1: PC and all IF/ID fields hold.
  5. Otherwise: IF/ID <= {imem_rdata, PC, PC+PC_INC, valid=1}; PC <= PC+PC_INC.
- HALTED: PC, IF/ID and all outputs are frozen with if_id_instr=NOP_INSTR. halted=1. All inputs except reset are ignored; the only exit is reset.
- PC arithmetic is modulo 2^PC_W: PC_INC wraps from 16'hFFFE to 16'h0000 with no error. Targets are used unmodified; odd targets are allowed.
- Output timing: opcode is combinational from the IF/ID register. halted is registered.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_HALT=0000, OP_ANDI=0001, OP_ORI=0010, OP_BGT=0100, OP_BLT=0101, OP_BEQ=0110, OP_JMP=0111, OP_LBU=1010, OP_SB=1011, OP_LW=1100, OP_SW=1101, OP_A=1111
  - NOP_INSTR, PC_W and INSTR_W defaults
  - the fetch state enum {RUN, HALTED}
- One sub-module: if_id_reg, the IF/ID pipeline register with load/hold/bubble controls. The PC and next-PC logic stay in fetch_unit.

Test Plan:
- Reset, then 4 free-running cycles with imem returning 16'h1234 -> imem_addr 0,2,4,6; if_id_pc 0,2,4; if_id_valid=1 from the second edge on; opcode=4'h1.
- pc_op=1, b_jmp=1, branch_target=16'h0040, if_flush=1 for 1 cycle -> next imem_addr=16'h0040; IF/ID shows NOP_INSTR with valid=0 for 1 cycle, then the instruction fetched at 16'h0040.
- pc_op=1, b_jmp=0, jump_target=16'h0100, stall=1 simultaneously -> redirect wins; imem_addr=16'h0100 on the next cycle.
- stall=1 for 3 cycles at PC=16'h0010 -> imem_addr and IF/ID unchanged for 3 cycles; resumes at 16'h0012.
- halt=1 together with if_flush=1 and pc_op=1 -> halted=1, PC frozen, opcode=4'b1000. Further pc_op/stall pulses have no effect; reset=0 for 1 edge returns to PC=0 with halted=0.
- PC preset via jump to 16'hFFFE with free-running fetch -> next imem_addr=16'h0000.
